// File: rtl/axi_lite_req_arbiter_if.sv
// Bundle between two request clients, the arbiter and an AXI-Lite master engine.
// cN_req stays high with a stable payload until that client's one-cycle cN_ack; m_*_req and m_*_done are single-cycle pulses.
interface axi_lite_req_arbiter_if;
    logic        c0_req,   c1_req;
    logic        c0_we,    c1_we;
    logic [31:0] c0_addr,  c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic [3:0]  c0_strb,  c1_strb;
    logic        c0_ack,   c1_ack;
    logic [31:0] c0_rdata, c1_rdata;
    logic [1:0]  c0_resp,  c1_resp;

    logic        m_wr_req, m_rd_req;
    logic [31:0] m_wr_addr, m_wr_data, m_rd_addr;
    logic [3:0]  m_wr_strb;
    logic        m_wr_done, m_rd_done;
    logic [1:0]  m_wr_resp, m_rd_resp;
    logic [31:0] m_rd_data;

    // Arbiter side
    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr,
        input  c0_wdata, c1_wdata, c0_strb, c1_strb,
        output c0_ack, c1_ack, c0_rdata, c1_rdata, c0_resp, c1_resp,
        output m_wr_req, m_rd_req, m_wr_addr, m_wr_data, m_rd_addr, m_wr_strb,
        input  m_wr_done, m_rd_done, m_wr_resp, m_rd_resp, m_rd_data
    );

    // Environment side: clients plus master engine
    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr,
        output c0_wdata, c1_wdata, c0_strb, c1_strb,
        input  c0_ack, c1_ack, c0_rdata, c1_rdata, c0_resp, c1_resp,
        input  m_wr_req, m_rd_req, m_wr_addr, m_wr_data, m_rd_addr, m_wr_strb,
        output m_wr_done, m_rd_done, m_wr_resp, m_rd_resp, m_rd_data
    );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Two-client round-robin arbiter in front of an AXI-Lite master; one transaction
// in flight, with a forced SLVERR-style completion when the master never answers.
module axi_lite_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi_lite_req_arbiter_if.slave        bus,
    output logic                         busy,
    output logic [1:0]                   grant,
    output logic [1:0]                   state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        last_c1;
    logic        owner_we;
    logic [1:0]  grant_q;
    logic [15:0] wait_cnt;
    logic [31:0] wr_addr_q, wr_data_q, rd_addr_q;
    logic [3:0]  wr_strb_q;
    logic [31:0] c0_rdata_q, c1_rdata_q;
    logic [1:0]  c0_resp_q, c1_resp_q;

    logic        any_req, pick_c1, done_hit, timeout_hit;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata, cpl_rdata;
    logic [3:0]  sel_strb;
    logic [1:0]  cpl_resp;
    logic        ack_c0, ack_c1, wr_pulse, rd_pulse;

    always_comb begin
        any_req   = bus.c0_req | bus.c1_req;
        // A lone requester always wins; on a tie the client not granted last wins.
        pick_c1   = bus.c1_req & (~bus.c0_req | ~last_c1);
        sel_we    = pick_c1 ? bus.c1_we    : bus.c0_we;
        sel_addr  = pick_c1 ? bus.c1_addr  : bus.c0_addr;
        sel_wdata = pick_c1 ? bus.c1_wdata : bus.c0_wdata;
        sel_strb  = pick_c1 ? bus.c1_strb  : bus.c0_strb;
        done_hit    = owner_we ? bus.m_wr_done : bus.m_rd_done;
        timeout_hit = (wait_cnt == TIMEOUT_LAST);
        cpl_resp  = done_hit ? (owner_we ? bus.m_wr_resp : bus.m_rd_resp) : 2'b10;
        cpl_rdata = (done_hit && !owner_we) ? bus.m_rd_data : 32'h0;
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        wr_pulse  = (state == ISSUE) &  owner_we;
        rd_pulse  = (state == ISSUE) & ~owner_we;
        ack_c0    = (state == ACK) & grant_q[0];
        ack_c1    = (state == ACK) & grant_q[1];
        state_dbg = state;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_c1    <= 1'b1;
            owner_we   <= 1'b0;
            grant_q    <= 2'b00;
            wait_cnt   <= 16'h0;
            wr_addr_q  <= 32'h0;
            wr_data_q  <= 32'h0;
            wr_strb_q  <= 4'h0;
            rd_addr_q  <= 32'h0;
            c0_rdata_q <= 32'h0;
            c1_rdata_q <= 32'h0;
            c0_resp_q  <= 2'b00;
            c1_resp_q  <= 2'b00;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant_q  <= pick_c1 ? 2'b10 : 2'b01;
                    last_c1  <= pick_c1;
                    owner_we <= sel_we;
                    if (sel_we) begin
                        wr_addr_q <= sel_addr;
                        wr_data_q <= sel_wdata;
                        wr_strb_q <= sel_strb;
                    end else begin
                        rd_addr_q <= sel_addr;
                    end
                end
                ISSUE: wait_cnt <= 16'h0;
                // A matching done takes priority over a timeout landing in the same cycle.
                WAIT: if (done_hit || timeout_hit) begin
                    if (grant_q[1]) begin
                        c1_resp_q  <= cpl_resp;
                        c1_rdata_q <= cpl_rdata;
                    end else begin
                        c0_resp_q  <= cpl_resp;
                        c0_rdata_q <= cpl_rdata;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                ACK: grant_q <= 2'b00;
                default: ;
            endcase
        end
    end

    assign grant         = grant_q;
    assign bus.c0_ack    = ack_c0;
    assign bus.c1_ack    = ack_c1;
    assign bus.c0_rdata  = c0_rdata_q;
    assign bus.c1_rdata  = c1_rdata_q;
    assign bus.c0_resp   = c0_resp_q;
    assign bus.c1_resp   = c1_resp_q;
    assign bus.m_wr_req  = wr_pulse;
    assign bus.m_rd_req  = rd_pulse;
    assign bus.m_wr_addr = wr_addr_q;
    assign bus.m_wr_data = wr_data_q;
    assign bus.m_wr_strb = wr_strb_q;
    assign bus.m_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Scoreboarded bench for axi_lite_req_arbiter: master-command and client-completion
// queues filled as stimulus is driven, drained by negedge monitors.
module tb_axi_lite_req_arbiter;
  logic       aclk = 1'b0;
  logic       areset;
  logic       busy;
  logic [1:0] grant;
  logic [1:0] state_dbg;

  axi_lite_req_arbiter_if bus ();

  axi_lite_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .busy      (busy),
    .grant     (grant),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [34:0] exp_q[$];   // {client, resp, rdata}
  logic [68:0] mexp_q[$];  // {we, addr, wdata, strb}
  logic        prev_ack   = 1'b0;
  logic        prev_mreq  = 1'b0;
  logic        last_mwe   = 1'b0;
  logic [31:0] last_maddr = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input bit c);
    return c ? bus.c1_ack : bus.c0_ack;
  endfunction

  // master-side monitor
  always @(negedge aclk) begin : mreq_mon
    logic [68:0] m;
    if (bus.m_wr_req === 1'b1 || bus.m_rd_req === 1'b1) begin
      check("mreq_both", 64'(bus.m_wr_req & bus.m_rd_req), 64'(0));
      check("mreq_pulse", 64'(prev_mreq), 64'(0));
      if (mexp_q.size() == 0) begin
        check("mreq_unexpected", 64'({bus.m_wr_req, bus.m_rd_req}), 64'(0));
      end else begin
        m = mexp_q.pop_front();
        check("m_is_write", 64'(bus.m_wr_req), 64'(m[68]));
        if (m[68]) begin
          check("m_wr_addr", 64'(bus.m_wr_addr), 64'(m[67:36]));
          check("m_wr_data", 64'(bus.m_wr_data), 64'(m[35:4]));
          check("m_wr_strb", 64'(bus.m_wr_strb), 64'(m[3:0]));
        end else begin
          check("m_rd_addr", 64'(bus.m_rd_addr), 64'(m[67:36]));
        end
        last_mwe   <= m[68];
        last_maddr <= m[67:36];
      end
    end
    prev_mreq <= (bus.m_wr_req === 1'b1) || (bus.m_rd_req === 1'b1);
  end

  // completion scoreboard
  always @(negedge aclk) begin : ack_mon
    logic [34:0] e;
    if (bus.c0_ack === 1'b1 || bus.c1_ack === 1'b1) begin
      check("ack_both", 64'(bus.c0_ack & bus.c1_ack), 64'(0));
      check("ack_pulse", 64'(prev_ack), 64'(0));
      check("m_addr_hold", 64'(last_mwe ? bus.m_wr_addr : bus.m_rd_addr), 64'(last_maddr));
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 64'({bus.c1_ack, bus.c0_ack}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_client", 64'(bus.c1_ack), 64'(e[34]));
        check("resp", 64'(e[34] ? bus.c1_resp : bus.c0_resp), 64'(e[33:32]));
        check("rdata", 64'(e[34] ? bus.c1_rdata : bus.c0_rdata), 64'(e[31:0]));
      end
    end
    prev_ack <= (bus.c0_ack === 1'b1) || (bus.c1_ack === 1'b1);
  end

  // driver tasks
  task automatic drive_client(input bit c, input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
    if (c) begin
      bus.c1_req = req; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wdata; bus.c1_strb = strb;
    end else begin
      bus.c0_req = req; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wdata; bus.c0_strb = strb;
    end
  endtask

  task automatic push_txn(input bit c, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rdata);
    mexp_q.push_back({we, addr, wdata, strb});
    exp_q.push_back({c, resp, we ? 32'h0 : rdata});
  endtask

  task automatic wait_mreq(input logic [1:0] exp_grant, input int exp_lat);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (bus.m_wr_req !== 1'b1 && bus.m_rd_req !== 1'b1 && n < 40);
    if (bus.m_wr_req !== 1'b1 && bus.m_rd_req !== 1'b1) begin
      check("mreq_seen", 64'(bus.m_wr_req | bus.m_rd_req), 64'(1));
    end else begin
      check("mreq_latency", 64'(n), 64'(exp_lat));
      check("grant", 64'(grant), 64'(exp_grant));
      check("busy_issue", 64'(busy), 64'(1));
    end
  endtask

  task automatic pulse_done(input bit wr, input int delay, input logic [1:0] resp, input logic [31:0] rdata);
    repeat (delay) @(negedge aclk);
    if (wr) begin
      bus.m_wr_done = 1'b1; bus.m_wr_resp = resp;
    end else begin
      bus.m_rd_done = 1'b1; bus.m_rd_resp = resp; bus.m_rd_data = rdata;
    end
    @(negedge aclk);
    bus.m_wr_done = 1'b0;
    bus.m_rd_done = 1'b0;
    bus.m_wr_resp = 2'b11;
    bus.m_rd_resp = 2'b11;
    bus.m_rd_data = 32'hDEAD_BEEF;
  endtask

  task automatic wait_ack(input bit c, input int exp_lat);
    int n = 0;
    while (ack_of(c) !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    if (ack_of(c) !== 1'b1) check("ack_seen", 64'(ack_of(c)), 64'(1));
    else                    check("ack_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic run_single(input bit c, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int delay, input logic [1:0] resp,
                            input logic [31:0] rdata);
    push_txn(c, we, addr, wdata, strb, resp, rdata);
    drive_client(c, 1'b1, we, addr, wdata, strb);
    wait_mreq(c ? 2'b10 : 2'b01, 1);
    pulse_done(we, delay, resp, rdata);
    wait_ack(c, 0);
    drive_client(c, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge aclk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          rc, rwe;
    logic [31:0] ra, rw, rr;
    logic [3:0]  rs;
    logic [1:0]  rp;
    int          dly;

    areset = 1'b1;
    drive_client(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_client(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.m_wr_done = 1'b0; bus.m_rd_done = 1'b0;
    bus.m_wr_resp = 2'b00; bus.m_rd_resp = 2'b00; bus.m_rd_data = 32'h0;
    repeat (3) @(negedge aclk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    check("rst_mreq", 64'({bus.m_wr_req, bus.m_rd_req}), 64'(0));
    check("rst_ack", 64'({bus.c0_ack, bus.c1_ack}), 64'(0));
    check("rst_m_wr_addr", 64'(bus.m_wr_addr), 64'(0));
    check("rst_c0_rdata", 64'(bus.c0_rdata), 64'(0));
    areset = 1'b0;
    @(negedge aclk);

    // continuous contention: c0, c1, c0, c1
    push_txn(1'b0, 1'b1, 32'h100, 32'hA0A0_0001, 4'hF, 2'b00, 32'h0);
    push_txn(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 2'b01, 32'hB0B0_0002);
    drive_client(1'b0, 1'b1, 1'b1, 32'h100, 32'hA0A0_0001, 4'hF);
    drive_client(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    wait_mreq(2'b01, 1);
    pulse_done(1'b1, 1, 2'b00, 32'h0);
    wait_ack(1'b0, 0);
    push_txn(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 2'b00, 32'hC0C0_0003);
    drive_client(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    wait_mreq(2'b10, 2);
    pulse_done(1'b0, 2, 2'b01, 32'hB0B0_0002);
    wait_ack(1'b1, 0);
    push_txn(1'b1, 1'b1, 32'h204, 32'hD0D0_0004, 4'h3, 2'b11, 32'h0);
    drive_client(1'b1, 1'b1, 1'b1, 32'h204, 32'hD0D0_0004, 4'h3);
    wait_mreq(2'b01, 2);
    pulse_done(1'b0, 1, 2'b00, 32'hC0C0_0003);
    wait_ack(1'b0, 0);
    drive_client(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_mreq(2'b10, 2);
    pulse_done(1'b1, 1, 2'b11, 32'h0);
    wait_ack(1'b1, 0);
    drive_client(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge aclk);

    // basic write and read
    run_single(1'b0, 1'b1, 32'h04, 32'h1111_1111, 4'hF, 3, 2'b00, 32'h0);
    run_single(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 2, 2'b00, 32'hAAAA_AAAA);
    run_single(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 1, 2'b01, 32'h1234_5678);

    // no done at all: forced error completion
    push_txn(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 2'b10, 32'h0);
    drive_client(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_mreq(2'b01, 1);
    wait_ack(1'b0, 9);
    drive_client(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge aclk);
    check("timeout_idle", 64'(busy), 64'(0));

    // write sees a read done first, then its own done
    push_txn(1'b0, 1'b1, 32'h50, 32'h5555_AAAA, 4'h5, 2'b01, 32'h0);
    drive_client(1'b0, 1'b1, 1'b1, 32'h50, 32'h5555_AAAA, 4'h5);
    wait_mreq(2'b01, 1);
    pulse_done(1'b0, 2, 2'b11, 32'hFFFF_FFFF);
    check("rd_done_ignored_ack", 64'(bus.c0_ack), 64'(0));
    check("rd_done_ignored_state", 64'(state_dbg), 64'(2));
    pulse_done(1'b1, 2, 2'b01, 32'h0);
    wait_ack(1'b0, 0);
    drive_client(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge aclk);

    // reset two cycles into WAIT aborts without ack
    mexp_q.push_back({1'b1, 32'h60, 32'h6666_6666, 4'hC});
    drive_client(1'b0, 1'b1, 1'b1, 32'h60, 32'h6666_6666, 4'hC);
    wait_mreq(2'b01, 1);
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    drive_client(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge aclk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_grant", 64'(grant), 64'(0));
    check("abort_state", 64'(state_dbg), 64'(0));
    check("abort_ack", 64'({bus.c0_ack, bus.c1_ack}), 64'(0));
    check("abort_m_wr", 64'({bus.m_wr_addr, bus.m_wr_data}), 64'(0));
    check("abort_m_strb", 64'(bus.m_wr_strb), 64'(0));
    check("abort_c0_resp", 64'(bus.c0_resp), 64'(0));
    check("abort_c1_rdata", 64'(bus.c1_rdata), 64'(0));
    areset = 1'b0;
    pulse_done(1'b1, 1, 2'b00, 32'h0);
    repeat (3) @(negedge aclk);
    check("late_done_idle", 64'({busy, state_dbg}), 64'(0));
    run_single(1'b0, 1'b1, 32'h70, 32'h7777_0000, 4'hA, 2, 2'b00, 32'h0);

    // random single-client traffic
    for (int i = 0; i < 6; i++) begin
      rc  = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      ra  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      rw  = $urandom;
      rr  = $urandom;
      rs  = 4'($urandom_range(0, 15));
      rp  = 2'($urandom_range(0, 3));
      dly = int'($urandom_range(1, 6));
      run_single(rc, rwe, ra, rw, rs, dly, rp, rr);
    end

    repeat (2) @(negedge aclk);
    check("cpl_queue_drained", 64'(exp_q.size()), 64'(0));
    check("mreq_queue_drained", 64'(mexp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
